// File: rtl/load_store_unit_if.sv
// Signal bundle for load_store_unit: instruction issue, memory port, writeback and status.
// master = the LSU side, slave = the pipeline/memory side.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic [31:0]       instruction;
  logic [31:0]       rs_data;
  logic [31:0]       rt_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              wb_en;
  logic [4:0]        wb_reg;
  logic [31:0]       wb_data;
  logic              busy;
  logic              done;
  logic [1:0]        err;

  modport master (
    input  start, instruction, rs_data, rt_data, mem_rdata, mem_ack,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           wb_en, wb_reg, wb_data, busy, done, err
  );

  modport slave (
    output start, instruction, rs_data, rt_data, mem_rdata, mem_ack,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           wb_en, wb_reg, wb_data, busy, done, err
  );
endinterface

// File: rtl/load_store_unit.sv
// MIPS I-type load/store unit: IDLE -> ADDR -> MEM -> DONE, little-endian byte lanes, wait timeout.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned halfword/word accesses with err=10.
module load_store_unit #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, ADDR, MEM, DONE} state_t;

  state_t      state_reg, state_next;
  logic [5:0]  op_reg;
  logic [4:0]  rt_idx_reg;
  logic [15:0] imm_reg;
  logic [31:0] rs_reg, rt_reg;
  logic [7:0]  wait_reg;
  logic [1:0]  err_pend_reg;
  logic [1:0]  lane_reg;
  logic [31:0] load_reg;

  logic        legal, is_store, is_unsigned, timeout;
  logic [1:0]  size;
  logic [31:0] ea, ea_eff, wdata, load_ext;
  logic [3:0]  be;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // opcode[1:0] encodes access size (00 byte, 01 half, 11 word), [2] unsigned, [3] store
  assign size        = op_reg[1:0];
  assign is_unsigned = op_reg[2];
  assign is_store    = op_reg[3];
  assign ea          = rs_reg + {{16{imm_reg[15]}}, imm_reg};
  assign timeout     = (wait_reg == 8'(MAX_WAIT - 1));

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((size == 2'b01) && ea[0]) || ((size == 2'b11) && (ea[1:0] != 2'b00));
`endif

  always_comb begin
    legal = 1'b0;
    case (op_reg)
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
      6'b101000, 6'b101001, 6'b101011: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Halfword/word accesses drop the offending low address bits before lane selection
  always_comb begin
    ea_eff = ea;
    be     = 4'b0001 << ea[1:0];
    wdata  = {4{rt_reg[7:0]}};
    case (size)
      2'b01: begin
        ea_eff = {ea[31:1], 1'b0};
        be     = ea[1] ? 4'b1100 : 4'b0011;
        wdata  = {2{rt_reg[15:0]}};
      end
      2'b11: begin
        ea_eff = {ea[31:2], 2'b00};
        be     = 4'b1111;
        wdata  = rt_reg;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_byte = bus.mem_rdata[7:0];
    case (lane_reg)
      2'd1:    rd_byte = bus.mem_rdata[15:8];
      2'd2:    rd_byte = bus.mem_rdata[23:16];
      2'd3:    rd_byte = bus.mem_rdata[31:24];
      default: rd_byte = bus.mem_rdata[7:0];
    endcase
    rd_half  = lane_reg[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    load_ext = bus.mem_rdata;
    case (size)
      2'b00:   load_ext = {{24{~is_unsigned & rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = {{16{~is_unsigned & rd_half[15]}}, rd_half};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    bus.mem_req = (state_reg == MEM);
    bus.busy    = (state_reg != IDLE);
    case (state_reg)
      IDLE: if (bus.start) state_next = ADDR;
      ADDR: begin
        state_next = MEM;
        if (!legal) state_next = DONE;
`ifdef LSU_MISALIGN_TRAP_EN
        else if (misaligned) state_next = DONE;
`endif
      end
      MEM:  if (bus.mem_ack || timeout) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg        <= '0;
      rt_idx_reg    <= '0;
      imm_reg       <= '0;
      rs_reg        <= '0;
      rt_reg        <= '0;
      wait_reg      <= '0;
      err_pend_reg  <= '0;
      lane_reg      <= '0;
      load_reg      <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      bus.wb_en     <= 1'b0;
      bus.wb_reg    <= '0;
      bus.wb_data   <= '0;
      bus.done      <= 1'b0;
      bus.err       <= '0;
    end else begin
      bus.done  <= 1'b0;
      bus.wb_en <= 1'b0;
      case (state_reg)
        IDLE: if (bus.start) begin
          op_reg     <= bus.instruction[31:26];
          rt_idx_reg <= bus.instruction[20:16];
          imm_reg    <= bus.instruction[15:0];
          rs_reg     <= bus.rs_data;
          rt_reg     <= bus.rt_data;
        end
        ADDR: begin
          bus.mem_we    <= is_store;
          bus.mem_addr  <= ea_eff[ADDR_W-1:0];
          bus.mem_be    <= be;
          bus.mem_wdata <= wdata;
          lane_reg      <= ea_eff[1:0];
          wait_reg      <= '0;
          err_pend_reg  <= legal ? 2'b00 : 2'b01;
`ifdef LSU_MISALIGN_TRAP_EN
          if (legal && misaligned) err_pend_reg <= 2'b10;
`endif
        end
        MEM: begin
          if (bus.mem_ack) begin
            load_reg <= load_ext;
          end else begin
            wait_reg <= wait_reg + 8'd1;
            if (timeout) err_pend_reg <= 2'b11;
          end
        end
        DONE: begin
          bus.done   <= 1'b1;
          bus.err    <= err_pend_reg;
          bus.wb_reg <= rt_idx_reg;
          if ((err_pend_reg == 2'b00) && !is_store) begin
            bus.wb_data <= load_reg;
            bus.wb_en   <= (rt_idx_reg != 5'd0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized + directed bench for load_store_unit against a byte-lane reference model.
module tb_load_store_unit;
  localparam int MAX_WAIT = 4;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [4:0]  exp_wb_reg;
  logic [31:0] exp_wb_data;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_we;
  int          last_lat, last_mem_cycles;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.ADDR_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One instruction end to end; ack_delay >= MAX_WAIT means the memory never acks.
  task automatic run_op(input string name, input logic [5:0] op, input logic [4:0] rt_idx,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                        input int ack_delay, input logic [31:0] rdata);
    int                 size, lane, exp_mem_cycles, mem_cycles;
    bit                 legal, sgn, st, mis, got_done;
    logic signed [31:0] simm;
    logic [31:0]        ea, addr_x, exp_wdata, exp_data, mask, exp_be;
    logic [1:0]         exp_err;

    legal = 1'b1; sgn = 1'b0; st = 1'b0; size = 4;
    case (op)
      6'b100000: begin size = 1; sgn = 1'b1; end
      6'b100001: begin size = 2; sgn = 1'b1; end
      6'b100011: size = 4;
      6'b100100: size = 1;
      6'b100101: size = 2;
      6'b101000: begin size = 1; st = 1'b1; end
      6'b101001: begin size = 2; st = 1'b1; end
      6'b101011: begin size = 4; st = 1'b1; end
      default:   legal = 1'b0;
    endcase
    simm      = $signed(imm);
    ea        = rs + simm;
    mis       = (ea % size) != 0;
    addr_x    = ea - (ea % size);
    lane      = int'(addr_x % 4);
    exp_be    = ((32'd1 << size) - 32'd1) << lane;
    exp_wdata = (size == 1) ? {24'd0, rt[7:0]} * 32'h01010101 :
                (size == 2) ? {16'd0, rt[15:0]} * 32'h00010001 : rt;
    mask      = (size == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * size)) - 64'd1);
    exp_data  = (rdata >> (8 * lane)) & mask;
    if (sgn && size < 4 && exp_data[8 * size - 1]) exp_data = exp_data | ~mask;

    if (!legal)                    exp_err = 2'b01;
    else if (TRAP && mis)          exp_err = 2'b10;
    else if (ack_delay >= MAX_WAIT) exp_err = 2'b11;
    else                           exp_err = 2'b00;
    exp_mem_cycles = (exp_err == 2'b01 || exp_err == 2'b10) ? 0 :
                     (exp_err == 2'b11) ? MAX_WAIT : ack_delay + 1;

    last_addr = '0; last_be = '0; last_wdata = '0; last_we = 1'b0; last_lat = -1;
    @(negedge clk);
    bus.start       = 1'b1;
    bus.instruction = {op, 5'($urandom), rt_idx, imm};
    bus.rs_data     = rs;
    bus.rt_data     = rt;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({name, ":busy"}, bus.busy, 1);

    mem_cycles = 0;
    got_done   = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bus.done) begin
        got_done = 1'b1;
        last_lat = cyc;
        break;
      end
      if (bus.mem_req) begin
        chk({name, ":mem_addr"},  bus.mem_addr,  addr_x);
        chk({name, ":mem_be"},    bus.mem_be,    exp_be);
        chk({name, ":mem_we"},    bus.mem_we,    st);
        chk({name, ":mem_wdata"}, bus.mem_wdata, exp_wdata);
        last_addr = bus.mem_addr; last_be = bus.mem_be;
        last_wdata = bus.mem_wdata; last_we = bus.mem_we;
        bus.mem_ack   = (mem_cycles == ack_delay);
        bus.mem_rdata = (mem_cycles == ack_delay) ? rdata : $urandom;
        mem_cycles++;
      end else begin
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
      end
      // Stray starts and changing operands while busy must have no effect
      bus.start       = 1'($urandom_range(0, 1));
      bus.instruction = $urandom;
      bus.rs_data     = $urandom;
      bus.rt_data     = $urandom;
      @(posedge clk); #1;
    end
    bus.start   = 1'b0;
    bus.mem_ack = 1'b0;
    last_mem_cycles = mem_cycles;

    exp_wb_reg = rt_idx;
    if (exp_err == 2'b00 && !st) exp_wb_data = exp_data;
    chk({name, ":done_seen"},  got_done, 1);
    chk({name, ":latency"},    last_lat, 2 + exp_mem_cycles);
    chk({name, ":mem_cycles"}, mem_cycles, exp_mem_cycles);
    chk({name, ":err"},        bus.err, exp_err);
    chk({name, ":wb_en"},      bus.wb_en, (exp_err == 2'b00 && !st && rt_idx != 5'd0));
    chk({name, ":wb_reg"},     bus.wb_reg, exp_wb_reg);
    chk({name, ":wb_data"},    bus.wb_data, exp_wb_data);

    @(posedge clk); #1;
    chk({name, ":done_pulse"}, bus.done, 0);
    chk({name, ":idle"},       bus.busy, 0);
    chk({name, ":err_hold"},   bus.err, exp_err);
    chk({name, ":wbd_hold"},   bus.wb_data, exp_wb_data);
    $display("op %s opc=%06b ea=%08h ack_delay=%0d err=%0d wb_data=%08h", name, op, ea,
             ack_delay, bus.err, bus.wb_data);
  endtask

  logic [5:0] op_tab [9];

  initial begin
    op_tab = '{6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
               6'b101000, 6'b101001, 6'b101011, 6'b000000};
    exp_wb_reg  = '0;
    exp_wb_data = '0;
    rst = 1'b1;
    bus.start = 1'b0; bus.instruction = '0; bus.rs_data = '0; bus.rt_data = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst:busy", bus.busy, 0);
    chk("rst:mem_req", bus.mem_req, 0);
    chk("rst:done", bus.done, 0);
    chk("rst:err", bus.err, 0);
    chk("rst:wb_en", bus.wb_en, 0);
    chk("rst:wb_data", bus.wb_data, 0);
    chk("rst:mem_addr", bus.mem_addr, 0);
    chk("rst:mem_be", bus.mem_be, 0);
    rst = 1'b0;

    run_op("lw_basic", 6'b100011, 5'd8, 32'h100, 32'h0, 16'h0004, 0, 32'hDEADBEEF);
    chk("lw_basic:addr", last_addr, 32'h104);
    chk("lw_basic:be", last_be, 4'b1111);
    chk("lw_basic:data", bus.wb_data, 32'hDEADBEEF);
    chk("lw_basic:lat", last_lat, 3);

    run_op("lb", 6'b100000, 5'd3, 32'h100, 32'h0, 16'h0003, 0, 32'h80FFFFFF);
    chk("lb:data", bus.wb_data, 32'hFFFFFF80);
    chk("lb:be", last_be, 4'b1000);
    run_op("lbu", 6'b100100, 5'd3, 32'h100, 32'h0, 16'h0003, 1, 32'h80FFFFFF);
    chk("lbu:data", bus.wb_data, 32'h00000080);

    run_op("sh", 6'b101001, 5'd9, 32'h200, 32'h1234ABCD, 16'h0002, 0, 32'h0);
    chk("sh:we", last_we, 1);
    chk("sh:be", last_be, 4'b1100);
    chk("sh:wdata", last_wdata, 32'hABCDABCD);

    run_op("timeout", 6'b100011, 5'd4, 32'h40, 32'h0, 16'h0000, 100, 32'h0);
    chk("timeout:mem_cycles", last_mem_cycles, 4);
    chk("timeout:err", bus.err, 2'b11);

    run_op("misalign", 6'b100011, 5'd5, 32'h100, 32'h0, 16'h0001, 0, 32'h11223344);
    chk("misalign:err", bus.err, TRAP ? 2'b10 : 2'b00);
    chk("misalign:addr", last_addr, TRAP ? 32'h0 : 32'h100);
    chk("misalign:mem_cycles", last_mem_cycles, TRAP ? 0 : 1);

    run_op("neg_imm", 6'b100101, 5'd6, 32'h200, 32'h0, 16'hFFFE, 3, 32'hBEEF1234);
    run_op("illegal", 6'b110000, 5'd7, 32'h0, 32'h0, 16'h0000, 0, 32'h0);
    run_op("lw_r0", 6'b100011, 5'd0, 32'h80, 32'h0, 16'h0000, 0, 32'hCAFEF00D);

    // Reset in the middle of a memory wait, with a start in the same cycle
    @(negedge clk);
    bus.start = 1'b1; bus.instruction = {6'b100011, 5'd1, 5'd2, 16'h0008}; bus.rs_data = 32'h300;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 10 && !bus.mem_req; i++) begin
      @(posedge clk); #1;
    end
    chk("midrst:in_mem", bus.mem_req, 1);
    @(posedge clk); #1;
    rst = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    chk("midrst:busy", bus.busy, 0);
    chk("midrst:mem_req", bus.mem_req, 0);
    chk("midrst:done", bus.done, 0);
    chk("midrst:wb_data", bus.wb_data, 0);
    chk("midrst:wb_reg", bus.wb_reg, 0);
    chk("midrst:mem_addr", bus.mem_addr, 0);
    rst = 1'b0; bus.start = 1'b0;
    @(posedge clk); #1;
    chk("midrst:start_dropped", bus.busy, 0);
    exp_wb_reg  = '0;
    exp_wb_data = '0;
    run_op("post_rst_lw", 6'b100011, 5'd12, 32'h1000, 32'h0, 16'h0010, 0, 32'h0BADC0DE);

    for (int n = 0; n < 40; n++) begin
      logic [5:0] rop;
      rop = op_tab[$urandom_range(0, 8)];
      if (rop == 6'b000000) rop = 6'($urandom);
      run_op("rand", rop, 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31)),
             $urandom, $urandom, 16'($urandom), $urandom_range(0, 5), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
